osc_param_controller: RTL

Register-driven configuration controller for the oscillator voice. It holds the host-writable parameters (frequency word, duty cycle, waveform enables, glide rate, run control) in shadow registers and stages them on a commit strobe. It applies them to the phase accumulator, waveform generators and mixer only at a phase wrap, so updates never glitch a cycle. When glide is enabled, it ramps the frequency word toward the new target instead of jumping.

---
 rtl/synth_pkg.sv | 40 ++++
 rtl/glide_stepper.sv | 32 +++
 rtl/osc_param_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the oscillator parameter controller
package synth_pkg;

  localparam int FREQ_W = 24;

  localparam logic [2:0] ADDR_FREQ0   = 3'd0;
  localparam logic [2:0] ADDR_FREQ1   = 3'd1;
  localparam logic [2:0] ADDR_FREQ2   = 3'd2;
  localparam logic [2:0] ADDR_DUTY    = 3'd3;
  localparam logic [2:0] ADDR_ENABLES = 3'd4;
  localparam logic [2:0] ADDR_GLIDE   = 3'd5;
  localparam logic [2:0] ADDR_CTRL    = 3'd6;

  localparam logic [7:0] DUTY_RST    = 8'h80;
  localparam logic [2:0] ENABLES_RST = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_GLIDE
  } state_t;

  // enables: bit0 square, bit1 sawtooth, bit2 triangle
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [7:0]        duty;
    logic [2:0]        enables;
    logic [3:0]        rate;
    logic              osc;
  } param_t;

  localparam param_t PARAM_RST = '{
    freq:    '0,
    duty:    DUTY_RST,
    enables: ENABLES_RST,
    rate:    4'd0,
    osc:     1'b0
  };

endpackage

// File: rtl/glide_stepper.sv
// rtl/glide_stepper.sv - one glide step of the frequency word toward its target
module glide_stepper
  import synth_pkg::*;
(
  input  logic [FREQ_W-1:0] current,
  input  logic [FREQ_W-1:0] target,
  input  logic [3:0]        rate,
  output logic [FREQ_W-1:0] freq_next,
  output logic              done
);

  logic signed [FREQ_W:0] diff;
  logic [FREQ_W-1:0]      mag;
  logic [FREQ_W-1:0]      shifted;
  logic [FREQ_W-1:0]      step;

  always_comb begin
    diff    = $signed({1'b0, target}) - $signed({1'b0, current});
    mag     = diff[FREQ_W] ? FREQ_W'(-diff) : diff[FREQ_W-1:0];
    shifted = mag >> rate;
    step    = (shifted == '0) ? FREQ_W'(1) : shifted;
    // Snapping to target when within one step keeps the word inside [start, target].
    done    = (mag <= step);
    if (done)
      freq_next = target;
    else if (diff[FREQ_W])
      freq_next = current - step;
    else
      freq_next = current + step;
  end

endmodule

// File: rtl/osc_param_controller.sv
// rtl/osc_param_controller.sv - shadow/staged/active oscillator parameters applied at phase wrap
module osc_param_controller
  import synth_pkg::*;
#(
  parameter int GLIDE_DIV = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  input  logic [23:0]       phase_in,
  output logic [FREQ_W-1:0] frequency,
  output logic [7:0]        duty_cycle,
  output logic              enable_square,
  output logic              enable_sawtooth,
  output logic              enable_triangle,
  output logic              osc_enable,
  output logic              pending,
  output logic              glide_active
);

  localparam int CNT_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

  param_t            shadow;
  param_t            shadow_nxt;
  param_t            staged;
  state_t            state;
  logic [FREQ_W-1:0] target;
  logic [3:0]        rate;
  logic              prev_msb;
  logic [CNT_W-1:0]  tick_cnt;
  logic              wrap;
  logic              tick;
  logic              apply;
  logic              jump;
  logic [FREQ_W-1:0] step_freq;
  logic              step_done;
  logic              unused_phase;

  assign unused_phase = ^phase_in[22:0];
  assign wrap  = prev_msb & ~phase_in[23];
  assign tick  = (tick_cnt == CNT_W'(GLIDE_DIV - 1));
  // A stopped oscillator never wraps, so it takes the staged set right away.
  assign apply = (state == ST_PENDING) && (wrap || !osc_enable);
  assign jump  = (staged.rate == 4'd0) || !osc_enable;

  // Write merged into shadow first so a same-cycle commit captures it.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_en) begin
      case (wr_addr)
        ADDR_FREQ0:   shadow_nxt.freq[7:0]   = wr_data;
        ADDR_FREQ1:   shadow_nxt.freq[15:8]  = wr_data;
        ADDR_FREQ2:   shadow_nxt.freq[23:16] = wr_data;
        ADDR_DUTY:    shadow_nxt.duty        = wr_data;
        ADDR_ENABLES: shadow_nxt.enables     = wr_data[2:0];
        ADDR_GLIDE:   shadow_nxt.rate        = wr_data[3:0];
        ADDR_CTRL:    shadow_nxt.osc         = wr_data[0];
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= PARAM_RST;
      staged   <= PARAM_RST;
      prev_msb <= 1'b0;
    end else begin
      shadow   <= shadow_nxt;
      prev_msb <= phase_in[23];
      if (commit)
        staged <= shadow_nxt;
    end
  end

  glide_stepper u_glide_stepper (
    .current   (frequency),
    .target    (target),
    .rate      (rate),
    .freq_next (step_freq),
    .done      (step_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      frequency       <= '0;
      duty_cycle      <= DUTY_RST;
      enable_square   <= ENABLES_RST[0];
      enable_sawtooth <= ENABLES_RST[1];
      enable_triangle <= ENABLES_RST[2];
      osc_enable      <= 1'b0;
      target          <= '0;
      rate            <= 4'd0;
      tick_cnt        <= '0;
      pending         <= 1'b0;
      glide_active    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (commit) begin
            state   <= ST_PENDING;
            pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (apply) begin
            duty_cycle      <= staged.duty;
            enable_square   <= staged.enables[0];
            enable_sawtooth <= staged.enables[1];
            enable_triangle <= staged.enables[2];
            osc_enable      <= staged.osc;
            rate            <= staged.rate;
            target          <= staged.freq;
            tick_cnt        <= '0;
            if (jump)
              frequency <= staged.freq;
            // A commit on the applying wrap re-stages; any glide is frozen before it starts.
            if (commit) begin
              state <= ST_PENDING;
            end else if (jump) begin
              state   <= ST_IDLE;
              pending <= 1'b0;
            end else begin
              state        <= ST_GLIDE;
              pending      <= 1'b0;
              glide_active <= 1'b1;
            end
          end
        end
        ST_GLIDE: begin
          if (commit) begin
            state        <= ST_PENDING;
            pending      <= 1'b1;
            glide_active <= 1'b0;
          end else if (tick) begin
            frequency <= step_freq;
            tick_cnt  <= '0;
            if (step_done) begin
              state        <= ST_IDLE;
              glide_active <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        default: begin
          state        <= ST_IDLE;
          pending      <= 1'b0;
          glide_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
